intr_req_ctrl: RTL and testbench

- Multi-source interrupt request controller for the RAT CPU; it is the initiating side of the interrupt flag register.
- Synchronises asynchronous peripheral/button sources, detects rising edges and latches pending requests.
- Applies a CPU-written mask, selects the highest-priority source and drives the set strobe of the CPU interrupt flag.
- Holds the granted source ID until the CPU acknowledges and signals end-of-interrupt.

---
 rtl/intr_req_ctrl_pkg.sv | 15 +
 rtl/intr_req_ctrl_if.sv | 36 +++
 rtl/intr_req_ctrl_edge_sync.sv | 33 +++
 rtl/intr_req_ctrl.sv | 114 +++++++++++
 tb/tb_intr_req_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/intr_req_ctrl_pkg.sv
// Shared types and constants for the interrupt request controller.
// Ports: none. This package defines the FSM state type, the width of the
// granted-source ID and the largest supported source count.
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } intr_state_t;

  localparam int INTR_ID_W = 3;
  localparam int MAX_SRC   = 8;

endpackage

// File: rtl/intr_req_ctrl_if.sv
// Bus between the interrupt request controller and the RAT CPU.
// Signals:
//   mask_we, mask_din  - CPU write strobe and data for the mask register
//   intr_ack           - CPU took the interrupt (one-cycle pulse)
//   intr_eoi           - ISR wrote end-of-interrupt (one-cycle pulse)
//   intr_set           - drives the CPU interrupt flag set input
//   intr_id, id_valid  - granted source index and its qualifier
//   pend, mask         - pending-bit and mask registers, readable by the CPU
// Modports: master = controller side, slave = CPU side.
interface intr_req_ctrl_if
  import intr_pkg::*;
#(
  parameter int NUM_SRC = 8
);

  logic                 mask_we;
  logic [NUM_SRC-1:0]   mask_din;
  logic                 intr_ack;
  logic                 intr_eoi;
  logic                 intr_set;
  logic [INTR_ID_W-1:0] intr_id;
  logic                 id_valid;
  logic [NUM_SRC-1:0]   pend;
  logic [NUM_SRC-1:0]   mask;

  modport master (
    input  mask_we, mask_din, intr_ack, intr_eoi,
    output intr_set, intr_id, id_valid, pend, mask
  );

  modport slave (
    output mask_we, mask_din, intr_ack, intr_eoi,
    input  intr_set, intr_id, id_valid, pend, mask
  );

endinterface

// File: rtl/intr_req_ctrl_edge_sync.sv
// Per-source synchroniser and rising-edge detector.
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   src        - asynchronous level input
//   rise_pulse - one-cycle pulse after each synchronised rising edge
module intr_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // The history flop is cleared by reset, so a source held high through
  // reset produces exactly one edge once it has crossed the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/intr_req_ctrl.sv
// Multi-source interrupt request controller for the RAT CPU.
// Synchronises the sources, latches rising edges as pending bits, applies the
// CPU mask, grants the lowest-index eligible source and holds its ID until
// end-of-interrupt.
// Ports:
//   clk    - system clock, all logic on the rising edge
//   rst    - synchronous active-high reset
//   src_in - asynchronous level sources, a rising edge requests service
//   bus    - CPU-side interface (master modport): mask write, ack/eoi strobes,
//            flag set strobe, granted ID, pending and mask registers
module intr_req_ctrl
  import intr_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_in,
  intr_req_ctrl_if.master    bus
);

  intr_state_t          state_q;
  intr_state_t          state_d;
  logic [INTR_ID_W-1:0] id_q;
  logic [INTR_ID_W-1:0] id_d;
  logic [INTR_ID_W-1:0] prio_id;
  logic [NUM_SRC-1:0]   rise_vec;
  logic [NUM_SRC-1:0]   pend_q;
  logic [NUM_SRC-1:0]   mask_q;
  logic [NUM_SRC-1:0]   clr_vec;
  logic [NUM_SRC-1:0]   eligible;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    intr_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk        (clk),
      .rst        (rst),
      .src        (src_in[g]),
      .rise_pulse (rise_vec[g])
    );
  end

  assign eligible = pend_q & mask_q;

  // Descending scan so the lowest set index is the last assignment and wins.
  // Only indices below NUM_SRC are ever produced.
  always_comb begin
    prio_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        prio_id = INTR_ID_W'(i);
      end
    end
  end

  // Next-state logic. Once in REQ the grant is committed: neither mask
  // changes nor higher-priority arrivals are looked at until the ACK.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr_vec = '0;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = REQ;
          id_d    = prio_id;
        end
      end
      REQ: begin
        if (bus.intr_ack) begin
          state_d = SERVICE;
          for (int i = 0; i < NUM_SRC; i++) begin
            clr_vec[i] = (id_q == INTR_ID_W'(i));
          end
        end
      end
      SERVICE: begin
        if (bus.intr_eoi) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Edges are OR-ed in after the clear so a new edge coinciding with the
  // ACK of the same source keeps the bit pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pend_q  <= (pend_q & ~clr_vec) | rise_vec;
      if (bus.mask_we) begin
        mask_q <= bus.mask_din;
      end
    end
  end

  assign bus.intr_set = (state_q == REQ);
  assign bus.id_valid = (state_q != IDLE);
  assign bus.intr_id  = id_q;
  assign bus.pend     = pend_q;
  assign bus.mask     = mask_q;

endmodule

// File: tb/tb_intr_req_ctrl.sv
// Self-checking bench for intr_req_ctrl: a table of single-cycle vectors for
// reset and the single-source path, then directed sequences for priority,
// masking, set-wins collision, stray strobes and reset during service.
module tb_intr_req_ctrl;

  import intr_pkg::*;

  localparam int NSRC = 8;

  logic            clk;
  logic            rst;
  logic [NSRC-1:0] src_in;

  int errors;
  int checks;

  intr_req_ctrl_if #(.NUM_SRC(NSRC)) bus ();

  intr_req_ctrl #(
    .NUM_SRC     (NSRC),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .src_in (src_in),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] src;
    logic       mask_we;
    logic [7:0] mask_din;
    logic       ack;
    logic       eoi;
    logic       exp_set;
    logic       exp_valid;
    logic       chk_id;
    logic [2:0] exp_id;
    logic [7:0] exp_pend;
    logic [7:0] exp_mask;
  } vec_t;

  vec_t tbl [18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    rst          = v.rst;
    src_in       = v.src;
    bus.mask_we  = v.mask_we;
    bus.mask_din = v.mask_din;
    bus.intr_ack = v.ack;
    bus.intr_eoi = v.eoi;
    tick();
  endtask

  task automatic check_output(input vec_t v, input int idx);
    check($sformatf("vec%0d intr_set", idx), 32'(bus.intr_set), 32'(v.exp_set));
    check($sformatf("vec%0d id_valid", idx), 32'(bus.id_valid), 32'(v.exp_valid));
    check($sformatf("vec%0d pend", idx), 32'(bus.pend), 32'(v.exp_pend));
    check($sformatf("vec%0d mask", idx), 32'(bus.mask), 32'(v.exp_mask));
    if (v.chk_id) begin
      check($sformatf("vec%0d intr_id", idx), 32'(bus.intr_id), 32'(v.exp_id));
    end
  endtask

  task automatic expect_out(input string tag, input logic set, input logic valid,
                            input logic [7:0] pend);
    check({tag, " intr_set"}, 32'(bus.intr_set), 32'(set));
    check({tag, " id_valid"}, 32'(bus.id_valid), 32'(valid));
    check({tag, " pend"}, 32'(bus.pend), 32'(pend));
  endtask

  task automatic write_mask(input logic [7:0] m);
    bus.mask_we  = 1'b1;
    bus.mask_din = m;
    tick();
    bus.mask_we  = 1'b0;
  endtask

  // One-cycle pulse on the selected sources; returns after edge k+1.
  task automatic pulse_src(input logic [7:0] s);
    src_in = s;
    tick();
    src_in = '0;
    tick();
  endtask

  task automatic strobe_ack();
    bus.intr_ack = 1'b1;
    tick();
    bus.intr_ack = 1'b0;
  endtask

  task automatic strobe_eoi();
    bus.intr_eoi = 1'b1;
    tick();
    bus.intr_eoi = 1'b0;
  endtask

  initial begin
    logic seen_set;
    errors = 0;
    checks = 0;

    rst          = 1'b1;
    src_in       = 8'hFF;
    bus.mask_we  = 1'b0;
    bus.mask_din = '0;
    bus.intr_ack = 1'b0;
    bus.intr_eoi = 1'b0;

    // rst src we din ack eoi | set valid chk id pend mask
    tbl[0]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h00};
    tbl[2]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h00};
    tbl[4]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h00};
    tbl[5]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'hFF, 8'h00};
    tbl[6]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'hFF, 8'h00};
    tbl[7]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h00};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h08};
    tbl[9]  = '{1'b0, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h08};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h08};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h08, 8'h08};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 8'h08, 8'h08};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 8'h08, 8'h08};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 8'h00, 8'h08};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 8'h00, 8'h08};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h08};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h08};

    for (int i = 0; i < 18; i++) begin
      apply_stimulus(tbl[i]);
      check_output(tbl[i], i);
    end

    // Priority: sources 5 and 2 rise together, 2 first, then 5 without a new edge.
    write_mask(8'hFF);
    pulse_src(8'h24);
    tick();
    expect_out("prio pend latched", 1'b0, 1'b0, 8'h24);
    tick();
    expect_out("prio first req", 1'b1, 1'b1, 8'h24);
    check("prio first id", 32'(bus.intr_id), 32'd2);
    strobe_ack();
    expect_out("prio service", 1'b0, 1'b1, 8'h20);
    strobe_eoi();
    expect_out("prio back idle", 1'b0, 1'b0, 8'h20);
    tick();
    expect_out("prio second req", 1'b1, 1'b1, 8'h20);
    check("prio second id", 32'(bus.intr_id), 32'd5);
    strobe_ack();
    strobe_eoi();
    expect_out("prio done", 1'b0, 1'b0, 8'h00);

    // Masking: source 6 pends while masked, requests two edges after the unmask.
    write_mask(8'h00);
    pulse_src(8'h40);
    tick();
    seen_set = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen_set = seen_set | bus.intr_set;
    end
    check("mask no request", 32'(seen_set), 32'd0);
    check("mask pend held", 32'(bus.pend), 32'h40);
    write_mask(8'h40);
    expect_out("mask first edge", 1'b0, 1'b0, 8'h40);
    tick();
    expect_out("mask second edge", 1'b1, 1'b1, 8'h40);
    check("mask id", 32'(bus.intr_id), 32'd6);
    strobe_ack();
    strobe_eoi();

    // Set-wins collision: new edge on source 1 lands in the ACK cycle for ID 1.
    write_mask(8'h02);
    pulse_src(8'h02);
    tick();
    tick();
    expect_out("coll req", 1'b1, 1'b1, 8'h02);
    check("coll id", 32'(bus.intr_id), 32'd1);
    pulse_src(8'h02);
    strobe_ack();
    expect_out("coll pend kept", 1'b0, 1'b1, 8'h02);
    strobe_eoi();
    expect_out("coll idle", 1'b0, 1'b0, 8'h02);
    tick();
    expect_out("coll re-request", 1'b1, 1'b1, 8'h02);
    check("coll re-request id", 32'(bus.intr_id), 32'd1);

    // EOI in REQ is ignored; coincident ACK+EOI takes only the ACK.
    strobe_eoi();
    expect_out("stray eoi in req", 1'b1, 1'b1, 8'h02);
    bus.intr_ack = 1'b1;
    bus.intr_eoi = 1'b1;
    tick();
    bus.intr_ack = 1'b0;
    bus.intr_eoi = 1'b0;
    expect_out("ack+eoi in req", 1'b0, 1'b1, 8'h00);
    strobe_eoi();
    expect_out("eoi to idle", 1'b0, 1'b0, 8'h00);

    // ACK in IDLE changes nothing.
    strobe_ack();
    expect_out("stray ack in idle", 1'b0, 1'b0, 8'h00);
    tick();
    expect_out("idle after stray ack", 1'b0, 1'b0, 8'h00);

    // Reset while in SERVICE aborts everything.
    pulse_src(8'h06);
    tick();
    tick();
    expect_out("rst pre req", 1'b1, 1'b1, 8'h06);
    strobe_ack();
    expect_out("rst pre service", 1'b0, 1'b1, 8'h04);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("rst in service", 1'b0, 1'b0, 8'h00);
    check("rst mask", 32'(bus.mask), 32'h00);
    check("rst id", 32'(bus.intr_id), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
